circ_fifo: RTL and testbench
============================

CIRC_FIFO -- requirements
Module: circ_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 16: number of storage words, SHALL be a power of two and >= 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full threshold, SHALL be in 1..DEPTH-1.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty threshold, SHALL be in 1..DEPTH-1.
REQ-005 Port list, in order:
- clk  input  1  clock; single clock, all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write word.
- rd_en  input  1  read request.
- clr_err  input  1  clears the sticky error flags.
- rd_data  output  WIDTH  registered read word.
- rd_valid  output  1  rd_data holds a newly read word this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  log2(DEPTH)+1  words stored.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.

Function
REQ-006 Storage SHALL be a DEPTH x WIDTH circular buffer with a write pointer and a read pointer, each log2(DEPTH)+1 bits wide.
REQ-007 The low log2(DEPTH) bits of each pointer SHALL address the buffer; the pointer MSB SHALL be the wrap bit.
REQ-008 Each pointer SHALL increment by 1 on every accepted access and wrap modulo 2*DEPTH.
REQ-009 Write acceptance: a write SHALL be accepted iff wr_en=1 and full=0; an accepted write stores wr_data at the write address at the edge.
REQ-010 Read acceptance: a read SHALL be accepted iff rd_en=1 and empty=0.
REQ-011 Read latency: on an accepted read, rd_data SHALL take the word at the read address at the edge, and rd_valid SHALL be 1 for the following cycle only.
REQ-012 rd_data SHALL hold its last value when no read is accepted.
REQ-013 full and empty SHALL be evaluated on the pre-edge state; there is no fall-through.
- A write to an empty FIFO is not readable in the same cycle.
- A read of a full FIFO does not free space for a write in the same cycle.
REQ-014 count SHALL be computed as write pointer minus read pointer, modulo 2*DEPTH.
- Accepted write only: count +1.
- Accepted read only: count -1.
- Both accepted, or neither: count unchanged.
REQ-015 full, empty, almost_full and almost_empty SHALL be combinational decodes of count, and so reflect the post-edge state.
REQ-016 overflow SHALL set on any edge with wr_en=1 and full=1; underflow SHALL set on any edge with rd_en=1 and empty=1.
REQ-017 Rejected accesses SHALL change no pointer, no storage word and no data output.
REQ-018 clr_err=1 SHALL clear overflow and underflow at the edge; when a new error occurs in the same cycle, set SHALL win over clear.

Reset
REQ-019 When rst=1 at an edge, the block SHALL clear the following, overriding all other inputs:
- both pointers, count, rd_data, rd_valid, overflow, underflow to 0;
- flags to: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-020 Storage contents SHALL NOT be reset; reset during traffic SHALL discard all stored words.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-021 Write 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles -> count reaches 4, full=1, almost_full=1 from count 3, empty=0.
REQ-022 Full FIFO, then wr_en with 0xFF -> overflow=1, count stays 4; reading 4 words returns A1, A2, A3, A4, each with rd_valid one cycle after its rd_en; empty=1 after the last read.
REQ-023 Empty FIFO, rd_en=1 -> underflow=1, rd_valid=0, rd_data unchanged; then clr_err=1 -> underflow=0 on the next cycle.
REQ-024 count=2 with wr_en=rd_en=1 for 10 cycles on incrementing data -> count stays 2, and the pointers wrap past 2*DEPTH with output order preserved.
REQ-025 Empty FIFO, wr_en=rd_en=1 -> write accepted, read rejected, underflow=1, count=1. Full FIFO, wr_en=rd_en=1 -> read accepted, write rejected, overflow=1, count=3.
REQ-026 rst=1 asserted with count=3 and a read in flight -> next cycle count=0, empty=1, rd_valid=0, rd_data=0, both error flags 0.

Source files
------------

// File: rtl/circ_fifo.sv
// Single-clock circular FIFO with a registered read port, level flags and
// sticky overflow/underflow flags.
module circ_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  // Handshake: an access request (wr_en / rd_en) is accepted on the edge
  // where it is high and the FIFO is not full / not empty respectively,
  // judged on the pre-edge count. rd_valid is high for exactly the one
  // cycle after an accepted read; there is no back-pressure on rd_data.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic             wr_accept;
  logic             rd_accept;
  logic             wr_reject;
  logic             rd_reject;

  // Pointer MSB is the wrap bit, so the difference is the occupancy and
  // distinguishes full (DEPTH) from empty (0).
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;
  assign wr_reject = wr_en && full;
  assign rd_reject = rd_en && empty;

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_reject)    overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (rd_reject)    underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_circ_fifo.sv
// Directed bench for circ_fifo (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1):
// a table of per-cycle vectors plus a short hand-written latency sequence.
module tb_circ_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  circ_fifo #(
    .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    logic [2:0] cnt;
    logic       f;
    logic       e;
    logic       af;
    logic       ae;
    logic       rv;
    logic [7:0] rdd;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic add(input logic r, input logic w, input logic [7:0] wd,
                     input logic rd, input logic clr, input logic [2:0] c,
                     input logic f, input logic e, input logic af,
                     input logic ae, input logic rv, input logic [7:0] rdd,
                     input logic ov, input logic un);
    vec_t v;
    v.rst = r; v.wr = w; v.wd = wd; v.rd = rd; v.clr = clr;
    v.cnt = c; v.f = f; v.e = e; v.af = af; v.ae = ae;
    v.rv = rv; v.rdd = rdd; v.ov = ov; v.un = un;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [7:0] wd,
                       input logic rd, input logic clr);
    rst = r; wr_en = w; wr_data = wd; rd_en = rd; clr_err = clr;
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    //   rst w  wd     rd clr  cnt f  e  af ae rv rdd    ov un
    add(1, 0, 8'h00, 0, 0,  0, 0, 1, 0, 1, 0, 8'h00, 0, 0); // reset
    add(0, 1, 8'hA1, 0, 0,  1, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    add(0, 1, 8'hA2, 0, 0,  2, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'hA3, 0, 0,  3, 0, 0, 1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'hA4, 0, 0,  4, 1, 0, 1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'hFF, 0, 0,  4, 1, 0, 1, 0, 0, 8'h00, 1, 0); // overflow
    add(0, 0, 8'h00, 1, 0,  3, 0, 0, 1, 0, 1, 8'hA1, 1, 0);
    add(0, 0, 8'h00, 1, 0,  2, 0, 0, 0, 0, 1, 8'hA2, 1, 0);
    add(0, 0, 8'h00, 1, 0,  1, 0, 0, 0, 1, 1, 8'hA3, 1, 0);
    add(0, 0, 8'h00, 1, 0,  0, 0, 1, 0, 1, 1, 8'hA4, 1, 0);
    add(0, 0, 8'h00, 1, 0,  0, 0, 1, 0, 1, 0, 8'hA4, 1, 1); // underflow
    add(0, 0, 8'h00, 0, 1,  0, 0, 1, 0, 1, 0, 8'hA4, 0, 0); // clear
    add(0, 1, 8'hB0, 1, 0,  1, 0, 0, 0, 1, 0, 8'hA4, 0, 1); // wr+rd on empty
    add(0, 0, 8'h00, 0, 1,  1, 0, 0, 0, 1, 0, 8'hA4, 0, 0);
    add(0, 1, 8'hB1, 0, 0,  2, 0, 0, 0, 0, 0, 8'hA4, 0, 0);
    add(0, 1, 8'hC0, 1, 0,  2, 0, 0, 0, 0, 1, 8'hB0, 0, 0); // streaming
    add(0, 1, 8'hC1, 1, 0,  2, 0, 0, 0, 0, 1, 8'hB1, 0, 0);
    add(0, 1, 8'hC2, 1, 0,  2, 0, 0, 0, 0, 1, 8'hC0, 0, 0);
    add(0, 1, 8'hC3, 1, 0,  2, 0, 0, 0, 0, 1, 8'hC1, 0, 0);
    add(0, 1, 8'hC4, 1, 0,  2, 0, 0, 0, 0, 1, 8'hC2, 0, 0);
    add(0, 1, 8'hC5, 1, 0,  2, 0, 0, 0, 0, 1, 8'hC3, 0, 0);
    add(0, 1, 8'hC6, 1, 0,  2, 0, 0, 0, 0, 1, 8'hC4, 0, 0);
    add(0, 1, 8'hC7, 1, 0,  2, 0, 0, 0, 0, 1, 8'hC5, 0, 0);
    add(0, 1, 8'hC8, 1, 0,  2, 0, 0, 0, 0, 1, 8'hC6, 0, 0);
    add(0, 1, 8'hC9, 1, 0,  2, 0, 0, 0, 0, 1, 8'hC7, 0, 0);
    add(0, 1, 8'hD0, 0, 0,  3, 0, 0, 1, 0, 0, 8'hC7, 0, 0); // rd_data holds
    add(0, 1, 8'hD1, 0, 0,  4, 1, 0, 1, 0, 0, 8'hC7, 0, 0);
    add(0, 1, 8'hD2, 1, 0,  3, 0, 0, 1, 0, 1, 8'hC8, 1, 0); // wr+rd on full
    add(1, 1, 8'hD3, 1, 0,  0, 0, 1, 0, 1, 0, 8'h00, 0, 0); // reset mid-traffic
    add(0, 0, 8'h00, 1, 0,  0, 0, 1, 0, 1, 0, 8'h00, 0, 1);
    add(0, 0, 8'h00, 1, 1,  0, 0, 1, 0, 1, 0, 8'h00, 0, 1); // set beats clear
    add(0, 0, 8'h00, 0, 1,  0, 0, 1, 0, 1, 0, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
      @(posedge clk);
      #1;
      check("count",        i, 32'(count),        32'(vecs[i].cnt));
      check("full",         i, 32'(full),         32'(vecs[i].f));
      check("empty",        i, 32'(empty),        32'(vecs[i].e));
      check("almost_full",  i, 32'(almost_full),  32'(vecs[i].af));
      check("almost_empty", i, 32'(almost_empty), 32'(vecs[i].ae));
      check("rd_valid",     i, 32'(rd_valid),     32'(vecs[i].rv));
      check("rd_data",      i, 32'(rd_data),      32'(vecs[i].rdd));
      check("overflow",     i, 32'(overflow),     32'(vecs[i].ov));
      check("underflow",    i, 32'(underflow),    32'(vecs[i].un));
    end

    // Hand sequence: write a few words after reset, then read each with a
    // bounded wait for rd_valid and confirm it is a single-cycle pulse.
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      @(negedge clk);
      drive(1'b0, 1'b1, d, 1'b0, 1'b0);
      exp_q.push_back(d);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      int waited;
      logic [7:0] e;
      e = exp_q.pop_front();
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      waited = 0;
      while (!rd_valid && waited < 5) begin
        @(negedge clk);
        waited++;
      end
      check("seq_rd_valid_seen", 100, 32'(rd_valid), 32'd1);
      check("seq_rd_data",       100, 32'(rd_data),  32'(e));
      @(negedge clk);
      check("seq_rd_valid_pulse", 100, 32'(rd_valid), 32'd0);
    end
    check("seq_empty_after", 100, 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
